picosoc_avl_bridge: RTL and testbench
=====================================

# picosoc_avl_bridge

Parametrised successor to the PicoSoC-to-Avalon SDRAM bridge; sits between the picorv32 iomem port and the `sdram_sdram` controller's Avalon slave port. Adds a write-posting buffer so stores retire in one cycle, strict read-after-write ordering, and a read timeout that returns an error word instead of hanging the CPU. One clock domain (`clk`); asynchronous active-high reset.

## Interface
- ADDR_W, 24: word-address width on both sides.
- WBUF_DEPTH, 4: posted-write buffer entries; power of two, 2..16.
- TIMEOUT, 256: max cycles from read command acceptance to `za_valid`; 0 disables the timeout.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  CPU request; held until `ready`.
- wen  in  4  byte strobes; 0 = read, nonzero = write.
- addr  in  ADDR_W  word address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid in the `ready` cycle.
- ready  out  1  single-cycle completion pulse.
- timeout_err  out  1  single-cycle pulse together with `ready` on a timed-out read.
- wbuf_level  out  $clog2(WBUF_DEPTH)+1  posted writes not yet accepted by Avalon.
- az_addr  out  ADDR_W  Avalon address.
- az_be_n  out  4  active-low byte enables (= ~wen for writes, 0000 for reads).
- az_cs  out  1  chip select; high for the entire command.
- az_data  out  32  Avalon write data.
- az_rd_n, az_wr_n  out  1 each  active-low read/write command.
- za_data  in  32  Avalon read data.
- za_valid  in  1  read data valid.
- za_waitrequest  in  1  slave stall; the command is held while high.

## Operation
- Accept rule: a request is taken only when `valid && !ready`; a request is never taken twice.
- Write: when the buffer is not full (level sampled at cycle start, no same-cycle pop credit), push {addr, ~wen, wdata}; `ready` is high the next cycle. When full, the CPU stalls until space frees.
- Drain engine: when the buffer is not empty and no read command is active, drive the head entry with `az_cs`=1 and `az_wr_n`=0. Pop on the first edge with `za_waitrequest`=0. Entries drain in FIFO order.
- Read FSM states: IDLE, WAIT_DRAIN, RD_CMD, RD_DATA, RD_ACK.
  - IDLE→WAIT_DRAIN on read accept.
  - WAIT_DRAIN→RD_CMD when the buffer is empty, no write is on the bus, and `stale`=0.
  - RD_CMD: `az_cs`=1, `az_rd_n`=0, `az_be_n`=0000, addr held. Go to RD_DATA when `za_waitrequest`=0.
  - RD_DATA: on `za_valid`, capture `za_data` and go to RD_ACK.
  - RD_ACK: `ready`=1 for one cycle, then IDLE.
- Timeout: a counter starts on RD_CMD acceptance (the edge where `za_waitrequest`=0). If the counter reaches TIMEOUT in RD_DATA, `rdata`=32'hFFFF_FFFF and `ready`=`timeout_err`=1 next cycle; `stale` is set.
- Stale read data: while `stale`=1, the next `za_valid` is discarded and clears `stale`. New reads wait in WAIT_DRAIN while `stale`=1. Writes continue to be accepted and drained.
- Avalon outputs and `ready`/`rdata` are driven from registers only; there is no combinational path from CPU inputs.

## Timing
- Reset values: `ready`=0, `timeout_err`=0, `rdata`=0, `wbuf_level`=0, `az_cs`=0, `az_rd_n`=1, `az_wr_n`=1, `az_be_n`=1111, `az_addr`=0, `az_data`=0. FSM=IDLE, `stale`=0.
- Reset mid-operation: all buffered writes are dropped, any in-flight command is abandoned, and outputs return to reset values immediately (asynchronous).
- Write latency: accept at edge N, `ready` in cycle N+1. The Avalon command is first driven no earlier than cycle N+1.
- Read latency with empty buffer, no waitrequest, `za_valid` k cycles after the command: `az_rd_n` low from cycle N+2; `ready` at cycle N+2+k+1.
- `wbuf_level`: +1 on push, −1 on pop, unchanged on a simultaneous push and pop; reaches WBUF_DEPTH exactly when full.
- TIMEOUT=0: RD_DATA waits indefinitely.

## Test plan
- Single write, addr 0x000010, wen 1111, data 0x12345678, waitrequest 0 -> `ready` 1 cycle after accept; Avalon write with az_addr 0x000010, az_be_n 0000, az_data 0x12345678; `wbuf_level` 1→0.
- Five back-to-back writes with WBUF_DEPTH=4 and waitrequest held high -> four writes get `ready` at one per accept; the fifth stalls until waitrequest drops; `wbuf_level` peaks at 4.
- Write 0xCAFEF00D to 0x20, then immediately read 0x20 with slow drain (waitrequest high 10 cycles) -> the read command issues only after the write pops; `rdata` is 0xCAFEF00D.
- Byte write wen 0100 -> az_be_n 1011; a subsequent read has az_be_n 0000.
- Read with `za_valid` never asserted, TIMEOUT=16 -> `ready`+`timeout_err` 17 cycles after command acceptance; `rdata` 0xFFFFFFFF. A late `za_valid` with 0xAAAA5555 is discarded; the next read returns its own data.
- Assert `reset` while 3 writes are buffered and a read is in RD_DATA -> all outputs are at reset values the same cycle; after release, `wbuf_level`=0 and no Avalon command is issued.

Source files
------------

// File: rtl/picosoc_avl_bridge_if.sv
// Bus bundle between the picorv32 iomem port and the sdram_sdram Avalon slave.
// Latency: none, signal grouping only.
// Backpressure: carries valid/ready on the CPU side and za_waitrequest on the Avalon side.
interface picosoc_avl_bridge_if #(
  parameter int ADDR_W = 24
);
  // CPU iomem side
  logic              valid;
  logic [3:0]        wen;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              timeout_err;

  // Avalon side
  logic [ADDR_W-1:0] az_addr;
  logic [3:0]        az_be_n;
  logic              az_cs;
  logic [31:0]       az_data;
  logic              az_rd_n;
  logic              az_wr_n;
  logic [31:0]       za_data;
  logic              za_valid;
  logic              za_waitrequest;

  // The bridge answers CPU requests and drives Avalon commands.
  modport slave (
    input  valid, wen, addr, wdata, za_data, za_valid, za_waitrequest,
    output rdata, ready, timeout_err,
    output az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n
  );

  // The surrounding system: CPU issues requests, SDRAM controller answers.
  modport master (
    output valid, wen, addr, wdata, za_data, za_valid, za_waitrequest,
    input  rdata, ready, timeout_err,
    input  az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n
  );
endinterface

// File: rtl/picosoc_avl_bridge.sv
// picorv32 iomem -> Avalon bridge with a posted-write buffer, read-after-write ordering and read timeout.
// Latency: write ready 1 cycle after accept; read ready 3 cycles + Avalon read latency after accept (empty buffer).
// Backpressure: CPU stalls while the write buffer is full or a read is pending; Avalon command held while za_waitrequest.
module picosoc_avl_bridge #(
  parameter int ADDR_W     = 24,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  picosoc_avl_bridge_if.slave         bus,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_level
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(WBUF_DEPTH);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DRAIN,
    RD_CMD,
    RD_DATA,
    RD_ACK
  } rd_state_t;

  rd_state_t state, state_nxt;

  // Posted-write storage; only pointers and level are reset, so a reset drops every entry.
  logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
  logic [3:0]        buf_be_n [WBUF_DEPTH];
  logic [31:0]       buf_data [WBUF_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;

  logic [ADDR_W-1:0] rd_addr;
  logic              stale;
  logic [TW-1:0]     to_cnt;

  logic              ready_q, terr_q;
  logic [31:0]       rdata_q;
  logic              cs_q, rd_n_q, wr_n_q;
  logic [3:0]        be_n_q;
  logic [ADDR_W-1:0] az_addr_q;
  logic [31:0]       az_data_q;

  logic buf_full, buf_empty, wr_take, rd_take, push, pop;
  logic bus_accept, wr_on_bus, launch_rd, launch_wr, timed_out;

  // Fullness uses the level at cycle start: a pop in the same cycle does not make room.
  assign buf_full   = (level == FULL_LVL);
  assign buf_empty  = (level == '0);
  // ready_q masks the cycle in which the CPU still holds the request it was just answered for.
  assign wr_take    = bus.valid && !ready_q && (state == IDLE) && (bus.wen != 4'b0000) && !buf_full;
  assign rd_take    = bus.valid && !ready_q && (state == IDLE) && (bus.wen == 4'b0000);
  assign push       = wr_take;
  assign bus_accept = cs_q && !bus.za_waitrequest;
  assign wr_on_bus  = cs_q && !wr_n_q;
  assign pop        = bus_accept && !wr_n_q;
  // to_cnt counts cycles since the command cycle, so the error reply lands TIMEOUT+1 cycles after it.
  assign timed_out  = (TIMEOUT != 0) && (state == RD_DATA) && !bus.za_valid && (to_cnt == TO_LIMIT);
  assign launch_rd  = (state == WAIT_DRAIN) && (state_nxt == RD_CMD);
  assign launch_wr  = !cs_q && !buf_empty && (state != RD_CMD) && !launch_rd;

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read FSM next state: reads wait behind buffered writes and behind an unclaimed stale reply.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (rd_take) state_nxt = WAIT_DRAIN;
      WAIT_DRAIN: if (buf_empty && !wr_on_bus && !stale) state_nxt = RD_CMD;
      RD_CMD:     if (!bus.za_waitrequest) state_nxt = RD_DATA;
      RD_DATA:    if (bus.za_valid || timed_out) state_nxt = RD_ACK;
      RD_ACK:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Write buffer payload.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= bus.addr;
      buf_be_n[wr_ptr] <= ~bus.wen;
      buf_data[wr_ptr] <= bus.wdata;
    end
  end

  // Write buffer pointers and occupancy; an entry counts until Avalon accepts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Read address capture, timeout counter and stale-reply tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      to_cnt  <= '0;
      stale   <= 1'b0;
    end else begin
      if (rd_take) rd_addr <= bus.addr;
      if (state == RD_CMD && !bus.za_waitrequest) to_cnt <= TW'(1);
      else if (state == RD_DATA && TIMEOUT != 0 && to_cnt != TO_LIMIT) to_cnt <= to_cnt + TW'(1);
      if (timed_out) stale <= 1'b1;
      else if (stale && bus.za_valid) stale <= 1'b0;
    end
  end

  // CPU response registers: one-cycle ready for posted writes and completed reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      terr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= wr_take || (state == RD_DATA && state_nxt == RD_ACK);
      terr_q  <= timed_out;
      if (state == RD_DATA && bus.za_valid) rdata_q <= bus.za_data;
      else if (timed_out)                   rdata_q <= 32'hFFFF_FFFF;
    end
  end

  // Avalon command register: one command at a time, dropped for a cycle after each acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q      <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      be_n_q    <= 4'hF;
      az_addr_q <= '0;
      az_data_q <= '0;
    end else if (bus_accept) begin
      cs_q   <= 1'b0;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      be_n_q <= 4'hF;
    end else if (launch_rd) begin
      cs_q      <= 1'b1;
      rd_n_q    <= 1'b0;
      wr_n_q    <= 1'b1;
      be_n_q    <= 4'h0;
      az_addr_q <= rd_addr;
    end else if (launch_wr) begin
      cs_q      <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b0;
      be_n_q    <= buf_be_n[rd_ptr];
      az_addr_q <= buf_addr[rd_ptr];
      az_data_q <= buf_data[rd_ptr];
    end
  end

  assign bus.ready       = ready_q;
  assign bus.timeout_err = terr_q;
  assign bus.rdata       = rdata_q;
  assign bus.az_cs       = cs_q;
  assign bus.az_rd_n     = rd_n_q;
  assign bus.az_wr_n     = wr_n_q;
  assign bus.az_be_n     = be_n_q;
  assign bus.az_addr     = az_addr_q;
  assign bus.az_data     = az_data_q;
  assign wbuf_level      = level;

endmodule

// File: tb/tb_picosoc_avl_bridge.sv
// Scoreboard bench for picosoc_avl_bridge: CPU driver, Avalon slave model, output monitor.
// Latency: checks write/read/timeout reply cycles against hand-computed values.
// Backpressure: exercises full write buffer, held waitrequest and stale read replies.
module tb_picosoc_avl_bridge;
  localparam int ADDR_W = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] wbuf_level;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  picosoc_avl_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  picosoc_avl_bridge #(.ADDR_W(ADDR_W), .WBUF_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .wbuf_level(wbuf_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic is_rd; logic [31:0] rdata; logic terr; } cpu_exp_t;
  typedef struct { logic is_wr; logic [23:0] addr; logic [3:0] be_n; logic [31:0] data; } avl_exp_t;
  cpu_exp_t exp_cpu[$];
  avl_exp_t exp_avl[$];
  cpu_exp_t mc;
  avl_exp_t ma;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Avalon slave model: 256-word memory, read data rd_lat cycles after command acceptance.
  logic [31:0] mem [256];
  int  rd_lat = 2;
  bit  drop_rd = 1'b0;
  int  inject_req = 0;
  int  inject_done = 0;

  initial begin
    int rd_cd;
    logic [31:0] pend, d;
    logic acc_rd, acc_wr;
    logic [7:0] a;
    logic [3:0] ben;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.za_valid = 1'b0;
    bus.za_data = 32'h0;
    rd_cd = 0;
    pend = 32'h0;
    forever begin
      @(negedge clk);
      acc_rd = !reset && bus.az_cs && !bus.az_rd_n && !bus.za_waitrequest;
      acc_wr = !reset && bus.az_cs && !bus.az_wr_n && !bus.za_waitrequest;
      a = bus.az_addr[7:0];
      ben = bus.az_be_n;
      d = bus.az_data;
      @(posedge clk);
      #1;
      bus.za_valid = 1'b0;
      if (reset) rd_cd = 0;
      if (acc_wr) for (int b = 0; b < 4; b++) if (!ben[b]) mem[a][8*b +: 8] = d[8*b +: 8];
      if (acc_rd && !drop_rd) begin
        rd_cd = rd_lat;
        pend = mem[a];
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          bus.za_valid = 1'b1;
          bus.za_data = pend;
        end
      end else if (inject_req != inject_done) begin
        inject_done++;
        bus.za_valid = 1'b1;
        bus.za_data = 32'hAAAA_5555;
      end
    end
  end

  // Monitor: pop and compare whenever the bridge answers the CPU or Avalon accepts a command.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ready) begin
        if (exp_cpu.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: got ready=1, expected no response");
        end else begin
          mc = exp_cpu.pop_front();
          chk("rsp_timeout_err", bus.timeout_err, mc.terr);
          if (mc.is_rd) chk("rsp_rdata", bus.rdata, mc.rdata);
        end
      end else if (bus.timeout_err) begin
        checks++; errors++;
        $display("FAIL stray_timeout_err: got timeout_err=1 without ready, expected 0");
      end
      if (bus.az_cs && !bus.az_rd_n) chk("raw_order_level", wbuf_level, 0);
      if (bus.az_cs && !bus.za_waitrequest) begin
        if (exp_avl.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_avl_cmd: got command to 0x%0h, expected none", bus.az_addr);
        end else begin
          ma = exp_avl.pop_front();
          chk("avl_kind", {bus.az_wr_n, bus.az_rd_n}, ma.is_wr ? 2'b01 : 2'b10);
          chk("avl_addr", bus.az_addr, ma.addr);
          chk("avl_be_n", bus.az_be_n, ma.be_n);
          if (ma.is_wr) chk("avl_data", bus.az_data, ma.data);
        end
      end
    end
  end

  // Issue one CPU request (call just after a rising edge) and wait for ready.
  task automatic cpu_req(input logic [3:0] w, input logic [23:0] a, input logic [31:0] d,
                         output int lat, output int rdy_cyc);
    int start;
    bit got;
    bus.valid = 1'b1; bus.wen = w; bus.addr = a; bus.wdata = d;
    start = cyc; got = 1'b0; lat = -1; rdy_cyc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        got = 1'b1;
        lat = cyc - start;
        rdy_cyc = cyc;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cpu_req_timeout: got no ready in 200 cycles, expected a response for addr 0x%0h", a);
    end
    @(posedge clk);
    #1;
    bus.valid = 1'b0; bus.wen = 4'h0;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [3:0] w, input logic [31:0] d,
                          input logic [3:0] exp_be_n, output int lat, output int rdy);
    exp_avl.push_back('{1'b1, a, exp_be_n, d});
    exp_cpu.push_back('{1'b0, 32'h0, 1'b0});
    cpu_req(w, a, d, lat, rdy);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] exp_d, input logic exp_terr,
                         output int lat, output int rdy);
    exp_avl.push_back('{1'b0, a, 4'b0000, 32'h0});
    exp_cpu.push_back('{1'b1, exp_d, exp_terr});
    cpu_req(4'h0, a, 32'h0, lat, rdy);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wbuf_level == 0 && !bus.az_cs) break;
    end
    chk(name, wbuf_level, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_accept(output int acc);
    bit seen;
    seen = 1'b0;
    acc = -1000;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.az_cs && !bus.az_rd_n && !bus.za_waitrequest) begin
        seen = 1'b1;
        acc = cyc;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.ready, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_wbuf_level"}, wbuf_level, 0);
    chk({tag, "_az_cs"}, bus.az_cs, 0);
    chk({tag, "_az_rd_n"}, bus.az_rd_n, 1);
    chk({tag, "_az_wr_n"}, bus.az_wr_n, 1);
    chk({tag, "_az_be_n"}, bus.az_be_n, 4'hF);
    chk({tag, "_az_addr"}, bus.az_addr, 0);
    chk({tag, "_az_data"}, bus.az_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200us, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, rdy, acc, drop_cyc, cs_seen;
    bus.valid = 1'b0; bus.wen = 4'h0; bus.addr = '0; bus.wdata = 32'h0;
    bus.za_waitrequest = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single full-word write with free Avalon.
    do_write(24'h000010, 4'b1111, 32'h1234_5678, 4'b0000, lat, rdy);
    chk("wr_ready_latency", lat, 1);
    chk("wr_level_after_accept", wbuf_level, 1);
    wait_idle("wr_level_drained");

    // Four writes fill the buffer against a stalled slave; the fifth waits for a pop.
    bus.za_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_write(24'h50 + 24'(i), 4'b1111, 32'hA000_0000 + 32'(i), 4'b0000, lat, rdy);
      chk("burst_wr_latency", lat, 1);
    end
    chk("wbuf_level_peak", wbuf_level, 4);
    fork
      do_write(24'h54, 4'b1111, 32'hA000_0004, 4'b0000, lat, rdy);
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.za_waitrequest = 1'b0;
        drop_cyc = cyc;
      end
    join
    chk("fifth_wr_ready_after_pop", rdy - drop_cyc, 2);
    wait_idle("burst_drained");
    chk("burst_avl_cmds_seen", exp_avl.size(), 0);

    // Read-after-write: read must follow a slowly draining write to the same address.
    bus.za_waitrequest = 1'b1;
    do_write(24'h000020, 4'b1111, 32'hCAFE_F00D, 4'b0000, lat, rdy);
    fork
      do_read(24'h000020, 32'hCAFE_F00D, 1'b0, lat, rdy);
      begin
        repeat (10) @(posedge clk);
        #1;
        bus.za_waitrequest = 1'b0;
      end
    join
    wait_idle("raw_drained");

    // Byte write then read: empty-buffer read latency is 2 + k + 1 with k = 2.
    do_write(24'h000030, 4'b0100, 32'h1122_3344, 4'b1011, lat, rdy);
    wait_idle("byte_drained");
    do_read(24'h000030, 32'h0022_0000, 1'b0, lat, rdy);
    chk("read_latency", lat, 5);

    // Timeout: no read data; error reply 17 cycles after the command cycle.
    drop_rd = 1'b1;
    fork
      do_read(24'h000040, 32'hFFFF_FFFF, 1'b1, lat, rdy);
      wait_rd_accept(acc);
    join
    chk("timeout_latency", rdy - acc, 17);
    drop_rd = 1'b0;
    // The next read waits for the late reply, which must be discarded.
    fork
      do_read(24'h000010, 32'h1234_5678, 1'b0, lat, rdy);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        inject_req++;
      end
    join
    chk("read_after_stale_latency", lat, 11);

    // Reset with three buffered writes and a read waiting behind them.
    bus.za_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_write(24'h70 + 24'(i), 4'b1111, 32'h7000_0000 + 32'(i), 4'b0000, lat, rdy);
      void'(exp_avl.pop_back());
    end
    chk("rstA_level_before", wbuf_level, 3);
    bus.valid = 1'b1; bus.wen = 4'h0; bus.addr = 24'h60;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("rstA");
    exp_cpu.delete();
    exp_avl.delete();
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.za_waitrequest = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.az_cs) cs_seen++;
    end
    chk("rstA_no_cmd_after", cs_seen, 0);
    chk("rstA_level_after", wbuf_level, 0);
    @(posedge clk);
    #1;

    // Reset while a read sits in RD_DATA.
    drop_rd = 1'b1;
    exp_avl.push_back('{1'b0, 24'h64, 4'b0000, 32'h0});
    bus.valid = 1'b1; bus.wen = 4'h0; bus.addr = 24'h64;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rstB_read_cmd_seen", exp_avl.size(), 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("rstB");
    exp_cpu.delete();
    exp_avl.delete();
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    drop_rd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    do_read(24'h000010, 32'h1234_5678, 1'b0, lat, rdy);
    chk("rstB_read_latency_after", lat, 5);

    repeat (5) @(posedge clk);
    chk("cpu_queue_empty", exp_cpu.size(), 0);
    chk("avl_queue_empty", exp_avl.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
